// File: rtl/store_buffer.sv
// store_buffer: post-commit store FIFO between the memory stage and the data cache.
// Committed BYTE/HALF/WORD stores enter a DEPTH-entry circular buffer as
// lane-aligned {address, lane data, byte enables}. They leave in order through a
// valid/ready drain port. Load lookups are answered in the same cycle.
// Build option: define SB_FORWARD_EN to forward fully covered loads. Without it,
// any byte overlap only produces a stall, and the forwarding mux is not built.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [ADDR_WIDTH-1:0]     push_addr,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic [1:0]                push_size,
  output logic                      push_misaligned,
  output logic                      drain_valid,
  input  logic                      drain_ready,
  output logic [ADDR_WIDTH-1:0]     drain_addr,
  output logic [DATA_WIDTH-1:0]     drain_data,
  output logic [DATA_WIDTH/8-1:0]   drain_be,
  input  logic                      ld_valid,
  input  logic [ADDR_WIDTH-1:0]     ld_addr,
  input  logic [1:0]                ld_size,
  output logic                      ld_hit,
  output logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      ld_stall,
  output logic                      empty
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } access_size_t;

  // Byte-enable pattern of an access of the given size at the given lane offset.
  // Size 11 yields an empty mask, so it never matches anything.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size,
                                                 input logic [LANE_BITS-1:0] off);
    logic [LANES-1:0] base;
    case (size)
      SZ_BYTE: base = LANES'(4'h1);
      SZ_HALF: base = LANES'(4'h3);
      SZ_WORD: base = LANES'(4'hF);
      default: base = '0;
    endcase
    return base << off;
  endfunction

  // Widens a byte-enable mask to a bit mask over the data bus.
  function automatic logic [DATA_WIDTH-1:0] byte_expand(input logic [LANES-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    for (int b = 0; b < LANES; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  // Entry storage
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [LANES-1:0]      be_q   [DEPTH];

  // Pointers, occupancy and the misalignment pulse
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;

  // Push-side decode
  logic [LANE_BITS-1:0]  push_off;
  logic [LANES-1:0]      push_be;
  logic [DATA_WIDTH-1:0] push_lane_data;
  logic [ADDR_WIDTH-1:0] push_lane_addr;
  logic                  push_bad;
  logic                  push_fire;
  logic                  push_write;
  logic                  drain_fire;

  assign push_off       = push_addr[LANE_BITS-1:0];
  assign push_be        = lane_mask(push_size, push_off);
  assign push_lane_data = (push_data << {push_off, 3'b000}) & byte_expand(push_be);
  assign push_lane_addr = {push_addr[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};

  // A full buffer refuses pushes even if the head drains this cycle.
  assign push_ready  = (count_q != CNT_W'(DEPTH));
  assign push_fire   = push_valid && push_ready;
  assign drain_valid = (count_q != '0);
  assign drain_fire  = drain_valid && drain_ready;
  assign empty       = (count_q == '0);

  // Classify the offered store; misaligned and size-11 stores are consumed but dropped.
  always_comb begin
    push_bad = 1'b0;
    case (push_size)
      SZ_BYTE: push_bad = 1'b0;
      SZ_HALF: push_bad = push_addr[0];
      SZ_WORD: push_bad = (push_addr[1:0] != 2'b00);
      default: push_bad = 1'b1;
    endcase
  end

  assign push_write = push_fire && !push_bad;

  // Head entry goes straight from storage to the dcache port.
  assign drain_addr = addr_q[head_q];
  assign drain_data = data_q[head_q];
  assign drain_be   = drain_valid ? be_q[head_q] : '0;
  assign push_misaligned = misaligned_q;

  // Next-state for pointers, occupancy and the misalignment pulse.
  // NOTE: every combinational output gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    misaligned_d = push_fire && push_bad;
    if (push_write) tail_d = tail_q + PTR_W'(1);
    if (drain_fire) head_d = head_q + PTR_W'(1);
    case ({push_write, drain_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Entry write port.
  // NOTE: the entry array is deliberately not reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_write) begin
      addr_q[tail_q] <= push_lane_addr;
      data_q[tail_q] <= push_lane_data;
      be_q[tail_q]   <= push_be;
    end
  end

  // Load lookup decode
  logic [LANE_BITS-1:0]  ld_off;
  logic [LANES-1:0]      ld_mask;
  logic [ADDR_WIDTH-1:0] ld_lane_addr;
  logic [LANES-1:0]      covered;
  logic [PTR_W-1:0]      idx;
`ifdef SB_FORWARD_EN
  logic [DATA_WIDTH-1:0] fwd_lanes;
`endif

  assign ld_off       = ld_addr[LANE_BITS-1:0];
  assign ld_mask      = lane_mask(ld_size, ld_off);
  assign ld_lane_addr = {ld_addr[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};

  // Scan valid entries oldest to youngest, so a younger store overwrites an older one per byte.
  // NOTE: blocking assignments here are intentional; later loop iterations must see earlier results.
  always_comb begin
    covered = '0;
    idx     = '0;
`ifdef SB_FORWARD_EN
    fwd_lanes = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == ld_lane_addr)) begin
        for (int b = 0; b < LANES; b++) begin
          if (be_q[idx][b] && ld_mask[b]) begin
            covered[b] = 1'b1;
`ifdef SB_FORWARD_EN
            fwd_lanes[b*8 +: 8] = data_q[idx][b*8 +: 8];
`endif
          end
        end
      end
    end
  end

`ifdef SB_FORWARD_EN
  // Full coverage forwards the merged bytes right-aligned; partial coverage stalls with zero data.
  always_comb begin
    ld_hit   = ld_valid && (ld_mask != '0) && (covered == ld_mask);
    ld_stall = ld_valid && (covered != '0) && (covered != ld_mask);
    ld_data  = ld_hit ? (fwd_lanes >> {ld_off, 3'b000}) : '0;
  end
`else
  // Without forwarding, any overlap with a buffered store stalls the load.
  always_comb begin
    ld_hit   = 1'b0;
    ld_data  = '0;
    ld_stall = ld_valid && (covered != '0);
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (default parameters 32/32/4).
// A table of single-cycle vectors covers the headline scenarios, hand-written
// sequences cover fill/wrap, full-with-drain and reset mid-drain, and a random
// phase is checked against a byte-address reference model of queued stores.
module tb_store_buffer;

`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [1:0]  push_size;
  logic        push_misaligned;
  logic        drain_valid;
  logic        drain_ready;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  drain_be;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        empty;

  store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
    .push_data(push_data), .push_size(push_size), .push_misaligned(push_misaligned),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
    .drain_data(drain_data), .drain_be(drain_be),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: a queue of accepted stores ----------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } st_t;

  st_t  sq[$];
  logic mis_m = 1'b0;

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Applied at each rising edge with the inputs present at that edge.
  task automatic model_update();
    bit   rdy, dfire, wr;
    st_t  e;
    if (!rst_n) begin
      sq.delete();
      mis_m = 1'b0;
    end else begin
      rdy   = sq.size() < 4;
      dfire = (sq.size() != 0) && drain_ready;
      wr    = push_valid && rdy && !is_mis(push_addr, push_size);
      mis_m = push_valid && rdy && is_mis(push_addr, push_size);
      e.addr = push_addr; e.size = push_size; e.data = push_data;
      if (dfire) void'(sq.pop_front());
      if (wr) sq.push_back(e);
    end
  endtask

  // Per requested byte address, the youngest store covering it supplies the byte.
  task automatic model_load(output logic hit, output logic [31:0] data, output logic stall);
    int          n, cov;
    logic [31:0] acc, a, off;
    logic [7:0]  byt;
    bit          found;
    hit = 1'b0; data = '0; stall = 1'b0;
    if (ld_valid) begin
      n = nbytes(ld_size);
      cov = 0;
      acc = '0;
      for (int i = 0; i < n; i++) begin
        a = ld_addr + 32'(i);
        found = 1'b0;
        for (int j = sq.size() - 1; j >= 0; j--) begin
          if (!found && a >= sq[j].addr && a < sq[j].addr + 32'(nbytes(sq[j].size))) begin
            off = a - sq[j].addr;
            byt = 8'(sq[j].data >> (8 * off));
            acc = acc | (32'(byt) << (8 * i));
            found = 1'b1;
          end
        end
        if (found) cov++;
      end
      if (FWD) begin
        hit   = (n > 0) && (cov == n);
        data  = hit ? acc : '0;
        stall = (cov > 0) && (cov != n);
      end else begin
        stall = (cov > 0);
      end
    end
  endtask

  // Compares every output against the model state for the current cycle.
  task automatic compare_all();
    logic        e_hit, e_stall;
    logic [31:0] e_ldata;
    logic [63:0] m, d;
    int          n, off;
    check("push_ready", 32'(push_ready), 32'(sq.size() < 4));
    check("empty", 32'(empty), 32'(sq.size() == 0));
    check("drain_valid", 32'(drain_valid), 32'(sq.size() != 0));
    if (sq.size() != 0) begin
      n   = nbytes(sq[0].size);
      off = int'(sq[0].addr[1:0]);
      m   = (64'd1 << (8 * n)) - 64'd1;
      d   = (64'(sq[0].data) & m) << (8 * off);
      check("drain_addr", drain_addr, sq[0].addr & 32'hFFFF_FFFC);
      check("drain_data", drain_data, d[31:0]);
      check("drain_be", 32'(drain_be), 32'(((1 << n) - 1) << off) & 32'hF);
    end else begin
      check("drain_be idle", 32'(drain_be), 32'h0);
    end
    check("push_misaligned", 32'(push_misaligned), 32'(mis_m));
    model_load(e_hit, e_ldata, e_stall);
    check("ld_hit", 32'(ld_hit), 32'(e_hit));
    check("ld_data", ld_data, e_ldata);
    check("ld_stall", 32'(ld_stall), 32'(e_stall));
  endtask

  task automatic drive(input logic pv, input logic [31:0] pa, input logic [1:0] ps,
                       input logic [31:0] pd, input logic dr, input logic lv,
                       input logic [31:0] la, input logic [1:0] ls);
    push_valid = pv; push_addr = pa; push_size = ps; push_data = pd;
    drain_ready = dr; ld_valid = lv; ld_addr = la; ld_size = ls;
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic cycle_begin();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        pv;
    logic [31:0] paddr;
    logic [1:0]  psize;
    logic [31:0] pdata;
    logic        dr;
    logic        lv;
    logic [31:0] laddr;
    logic [1:0]  lsize;
    logic        e_pready;
    logic        e_dvalid;
    logic [31:0] e_daddr;
    logic [31:0] e_ddata;
    logic [3:0]  e_dbe;
    logic        e_mis;
    logic        e_empty;
    logic        e_hit;
    logic [31:0] e_ldata;
    logic        e_stall;
  } vec_t;

  function automatic vec_t row(
      input logic pv, input logic [31:0] paddr, input logic [1:0] psize, input logic [31:0] pdata,
      input logic dr, input logic lv, input logic [31:0] laddr, input logic [1:0] lsize,
      input logic e_pready, input logic e_dvalid, input logic [31:0] e_daddr,
      input logic [31:0] e_ddata, input logic [3:0] e_dbe, input logic e_mis,
      input logic e_empty, input logic e_hit, input logic [31:0] e_ldata, input logic e_stall);
    vec_t v;
    v.pv = pv; v.paddr = paddr; v.psize = psize; v.pdata = pdata; v.dr = dr;
    v.lv = lv; v.laddr = laddr; v.lsize = lsize; v.e_pready = e_pready;
    v.e_dvalid = e_dvalid; v.e_daddr = e_daddr; v.e_ddata = e_ddata; v.e_dbe = e_dbe;
    v.e_mis = e_mis; v.e_empty = e_empty; v.e_hit = e_hit; v.e_ldata = e_ldata;
    v.e_stall = e_stall;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    // Vectors: pv paddr psize pdata dr lv laddr lsize | pready dvalid daddr ddata be mis empty hit ldata stall
    vecs[0]  = row(1, 32'h203, B, 32'hAB,       0, 0, 0, B,      1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
    vecs[1]  = row(0, 0, B, 0,                  1, 0, 0, B,      1, 1, 32'h200, 32'hAB000000, 4'h8, 0, 0, 0, 0, 0);
    vecs[2]  = row(1, 32'h40, W, 32'h11223344,  0, 0, 0, B,      1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
    vecs[3]  = row(1, 32'h41, B, 32'h99,        0, 1, 32'h40, W, 1, 1, 32'h40, 32'h11223344, 4'hF, 0, 0,
                   FWD, FWD ? 32'h11223344 : 32'h0, !FWD);
    vecs[4]  = row(0, 0, B, 0,                  0, 1, 32'h40, W, 1, 1, 32'h40, 32'h11223344, 4'hF, 0, 0,
                   FWD, FWD ? 32'h11229944 : 32'h0, !FWD);
    vecs[5]  = row(0, 0, B, 0,                  0, 1, 32'h42, H, 1, 1, 32'h40, 32'h11223344, 4'hF, 0, 0,
                   FWD, FWD ? 32'h00001122 : 32'h0, !FWD);
    vecs[6]  = row(0, 0, B, 0,                  1, 1, 32'h40, W, 1, 1, 32'h40, 32'h11223344, 4'hF, 0, 0,
                   FWD, FWD ? 32'h11229944 : 32'h0, !FWD);
    vecs[7]  = row(0, 0, B, 0,                  0, 1, 32'h40, W, 1, 1, 32'h40, 32'h00009900, 4'h2, 0, 0, 0, 0, 1);
    vecs[8]  = row(0, 0, B, 0,                  1, 1, 32'h41, B, 1, 1, 32'h40, 32'h00009900, 4'h2, 0, 0,
                   FWD, FWD ? 32'h00000099 : 32'h0, !FWD);
    vecs[9]  = row(1, 32'h301, H, 32'h1234,     0, 0, 0, B,      1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
    vecs[10] = row(1, 32'h302, W, 32'h5678,     0, 0, 0, B,      1, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0);
    vecs[11] = row(1, 32'h300, X, 32'h9ABC,     0, 0, 0, B,      1, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0);
    vecs[12] = row(0, 0, B, 0,                  0, 0, 0, B,      1, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0);
    vecs[13] = row(0, 0, B, 0,                  0, 0, 0, B,      1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
    vecs[14] = row(1, 32'h80, B, 32'h55,        0, 0, 0, B,      1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
    vecs[15] = row(0, 0, B, 0,                  0, 1, 32'h80, W, 1, 1, 32'h80, 32'h55, 4'h1, 0, 0, 0, 0, 1);
    vecs[16] = row(0, 0, B, 0,                  1, 1, 32'h84, W, 1, 1, 32'h80, 32'h55, 4'h1, 0, 0, 0, 0, 0);
    vecs[17] = row(0, 0, B, 0,                  0, 0, 0, B,      1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);

    // Reset: hold rst_n low across one edge, then check reset values.
    rst_n = 1'b0;
    drive(0, 0, B, 0, 0, 0, 0, B);
    @(posedge clk);
    #1;
    cycle_begin();
    check("reset push_ready", 32'(push_ready), 32'h1);
    check("reset drain_valid", 32'(drain_valid), 32'h0);
    check("reset empty", 32'(empty), 32'h1);
    check("reset drain_be", 32'(drain_be), 32'h0);
    check("reset push_misaligned", 32'(push_misaligned), 32'h0);
    cycle_end();
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pv, vecs[i].paddr, vecs[i].psize, vecs[i].pdata,
            vecs[i].dr, vecs[i].lv, vecs[i].laddr, vecs[i].lsize);
      cycle_begin();
      check($sformatf("vec%0d push_ready", i), 32'(push_ready), 32'(vecs[i].e_pready));
      check($sformatf("vec%0d drain_valid", i), 32'(drain_valid), 32'(vecs[i].e_dvalid));
      check($sformatf("vec%0d drain_be", i), 32'(drain_be), 32'(vecs[i].e_dbe));
      if (vecs[i].e_dvalid) begin
        check($sformatf("vec%0d drain_addr", i), drain_addr, vecs[i].e_daddr);
        check($sformatf("vec%0d drain_data", i), drain_data, vecs[i].e_ddata);
      end
      check($sformatf("vec%0d push_misaligned", i), 32'(push_misaligned), 32'(vecs[i].e_mis));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d ld_hit", i), 32'(ld_hit), 32'(vecs[i].e_hit));
      check($sformatf("vec%0d ld_data", i), ld_data, vecs[i].e_ldata);
      check($sformatf("vec%0d ld_stall", i), 32'(ld_stall), 32'(vecs[i].e_stall));
      cycle_end();
    end

    // Fill, refuse one extra push, drain in order; then a second round through the wrapped pointers.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1, 32'h100 + 32'(r * 'h80) + 32'(4 * i), W, 32'hA0 + 32'(16 * r + i), 0, 0, 0, B);
        cycle_begin();
        cycle_end();
      end
      drive(1, 32'h1F0, W, 32'hEE, 0, 0, 0, B);
      cycle_begin();
      check("fill push_ready", 32'(push_ready), 32'h0);
      cycle_end();
      drive(0, 0, B, 0, 1, 0, 0, B);
      for (int i = 0; i < 4; i++) begin
        cycle_begin();
        check("fill order addr", drain_addr, 32'h100 + 32'(r * 'h80) + 32'(4 * i));
        check("fill order data", drain_data, 32'hA0 + 32'(16 * r + i));
        cycle_end();
      end
      cycle_begin();
      check("fill drained empty", 32'(empty), 32'h1);
      cycle_end();
    end

    // Full buffer with push and drain in the same cycle: push refused, then accepted next cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h200 + 32'(4 * i), W, 32'hC0 + 32'(i), 0, 0, 0, B);
      cycle_begin();
      cycle_end();
    end
    drive(1, 32'h220, W, 32'h77, 1, 0, 0, B);
    cycle_begin();
    check("full+drain push_ready", 32'(push_ready), 32'h0);
    cycle_end();
    drive(1, 32'h220, W, 32'h77, 0, 0, 0, B);
    cycle_begin();
    check("after refuse push_ready", 32'(push_ready), 32'h1);
    check("after refuse head", drain_addr, 32'h204);
    cycle_end();
    drive(0, 0, B, 0, 0, 0, 0, B);
    cycle_begin();
    check("refill push_ready", 32'(push_ready), 32'h0);
    cycle_end();

    // Synchronous reset while draining discards everything.
    drive(0, 0, B, 0, 1, 0, 0, B);
    rst_n = 1'b0;
    cycle_begin();
    check("pre-reset drain_valid", 32'(drain_valid), 32'h1);
    cycle_end();
    rst_n = 1'b1;
    drive(0, 0, B, 0, 0, 0, 0, B);
    cycle_begin();
    check("post-reset empty", 32'(empty), 32'h1);
    check("post-reset drain_valid", 32'(drain_valid), 32'h0);
    cycle_end();

    // Random traffic in a small address window so stores and loads overlap often.
    for (int c = 0; c < 800; c++) begin
      logic [31:0] pa, la;
      logic [1:0]  ps, ls;
      int          r;
      r  = int'($urandom_range(0, 9));
      ps = (r < 4) ? B : (r < 7) ? H : (r < 9) ? W : X;
      pa = 32'h40 + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) begin
        if (ps == H) pa[0] = 1'b0;
        if (ps == W) pa[1:0] = 2'b00;
      end
      ls = 2'($urandom_range(0, 3));
      la = 32'h40 + 32'($urandom_range(0, 15));
      if (ls == H) la[0] = 1'b0;
      if (ls == W) la[1:0] = 2'b00;
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) < 6, pa, ps, $urandom,
            (c % 200 < 100) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 9) < 7, la, ls);
      cycle_begin();
      cycle_end();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
